// File: rtl/instr_issuer_if.sv
// Instruction-path bundle between the host-side bus/issuer and the video processor.
// Carries the CPU-side push handshake (in_*), the processor busy flag and the strobe outputs.
// master: host/bus side that pushes words and watches the strobe; slave: the issuer.
interface instr_issuer_if;
    logic        in_valid;
    logic [31:0] in_dataA;
    logic [31:0] in_dataB;
    logic        in_ready;
    logic        printtingScreen;
    logic [31:0] out_dataA;
    logic [31:0] out_dataB;
    logic        out_clk_en;

    modport master (
        output in_valid, in_dataA, in_dataB, printtingScreen,
        input  in_ready, out_dataA, out_dataB, out_clk_en
    );

    modport slave (
        input  in_valid, in_dataA, in_dataB, printtingScreen,
        output in_ready, out_dataA, out_dataB, out_clk_en
    );
endinterface

// File: rtl/instr_issuer.sv
// Queues CPU instruction words in a DEPTH-entry FIFO and issues them as one-cycle clk_en strobes.
// Latency: word accepted at edge N strobes from edge N+1 to N+2 when idle; pulses spaced GAP_CYCLES+2.
// Backpressure: in_ready drops when the FIFO is full; issue stalls while printtingScreen (synchronized) is high.
// Ports: clk, reset (sync, active-high); io (instr_issuer_if.slave); fifo_count, busy; issued_count, stall_count.
// Optional statistics counters enabled by defining ISSUER_STATS_EN; otherwise both counters read 0.
module instr_issuer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_issuer_if.slave          io,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic [CNT_W-1:0]       issued_count,
    output logic [CNT_W-1:0]       stall_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    // HOLD counts down from GAP_CYCLES-1 to 0, so it lasts exactly GAP_CYCLES cycles.
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [63:0]    mem_q [DEPTH];
    logic [63:0]    mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [31:0]    out_dataA_q, out_dataA_d;
    logic [31:0]    out_dataB_q, out_dataB_d;
    logic           out_clk_en_q, out_clk_en_d;
    logic           scr_s1_q, scr_busy_q;
    logic           in_ready, push, pop;

    assign in_ready      = (count_q != FULL_CNT);
    assign io.in_ready   = in_ready;
    assign io.out_dataA  = out_dataA_q;
    assign io.out_dataB  = out_dataB_q;
    assign io.out_clk_en = out_clk_en_q;
    assign fifo_count    = count_q;
    assign busy          = (state_q != IDLE) || (count_q != '0);

    // Issue control. The head word is registered straight into the output
    // flops on the popping edge so data and strobe rise together.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        out_dataA_d  = out_dataA_q;
        out_dataB_d  = out_dataB_q;
        out_clk_en_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !scr_busy_q) begin
                    pop          = 1'b1;
                    out_dataA_d  = mem_q[rd_ptr_q][63:32];
                    out_dataB_d  = mem_q[rd_ptr_q][31:0];
                    out_clk_en_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = HOLD;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping. A full FIFO refuses the push even when a pop happens
    // in the same cycle, because in_ready is derived from the registered count.
    always_comb begin
        push     = io.in_valid && in_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {io.in_dataA, io.in_dataB};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_dataA_q  <= '0;
            out_dataB_q  <= '0;
            out_clk_en_q <= 1'b0;
            scr_s1_q     <= 1'b0;
            scr_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_dataA_q  <= out_dataA_d;
            out_dataB_q  <= out_dataB_d;
            out_clk_en_q <= out_clk_en_d;
            // printtingScreen comes from another domain: two-flop synchronizer.
            scr_s1_q     <= io.printtingScreen;
            scr_busy_q   <= scr_s1_q;
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ISSUER_STATS_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (out_clk_en_q) begin
            issued_d = issued_q + 1'b1;
        end
        if ((state_q == IDLE) && (count_q != '0) && scr_busy_q) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_count = issued_q;
    assign stall_count  = stall_q;
`else
    assign issued_count = '0;
    assign stall_count  = '0;
`endif
endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: GAP_CYCLES=4 instance (dut) and GAP_CYCLES=0 instance (dut0).
// Expected words are queued when a push is driven and compared when a strobe is seen.
// Timing expectations are derived from push/release edge numbers.
module tb_instr_issuer;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_issuer_if bus ();
    instr_issuer_if bus0 ();

    logic [3:0]       fifo_count, fifo_count0;
    logic             busy, busy0;
    logic [CNT_W-1:0] issued_count, stall_count, issued0, stall0;

    instr_issuer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .io(bus),
        .fifo_count(fifo_count), .busy(busy),
        .issued_count(issued_count), .stall_count(stall_count)
    );

    instr_issuer #(.DEPTH(DEPTH), .GAP_CYCLES(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset), .io(bus0),
        .fifo_count(fifo_count0), .busy(busy0),
        .issued_count(issued0), .stall_count(stall0)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [63:0] sb[$];
    logic [63:0] sb0[$];
    int          pt[$];
    int          pt0[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe monitors: each pulse must match the oldest outstanding word.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (bus.out_clk_en === 1'b1) begin
            chk("pulse_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_dataA", 64'(bus.out_dataA), 64'(e[63:32]));
                chk("out_dataB", 64'(bus.out_dataB), 64'(e[31:0]));
            end
            pt.push_back(cyc);
        end
    end

    always @(negedge clk) begin : mon0
        logic [63:0] e0;
        if (bus0.out_clk_en === 1'b1) begin
            chk("pulse0_has_entry", 64'(sb0.size() != 0), 64'd1);
            if (sb0.size() != 0) begin
                e0 = sb0.pop_front();
                chk("out0_dataA", 64'(bus0.out_dataA), 64'(e0[63:32]));
                chk("out0_dataB", 64'(bus0.out_dataB), 64'(e0[31:0]));
            end
            pt0.push_back(cyc);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus0.in_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        sb.delete();
        sb0.delete();
        pt.delete();
        pt0.delete();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit acc);
        bus.in_valid = 1'b1;
        bus.in_dataA = a;
        bus.in_dataB = b;
        chk("in_ready", 64'(bus.in_ready), 64'(acc));
        if (acc) sb.push_back({a, b});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic push0(input logic [31:0] a, input logic [31:0] b);
        bus0.in_valid = 1'b1;
        bus0.in_dataA = a;
        bus0.in_dataB = b;
        chk("in0_ready", 64'(bus0.in_ready), 64'd1);
        sb0.push_back({a, b});
        tick();
        bus0.in_valid = 1'b0;
    endtask

    initial begin
        int n, m, e, p1, r, d, cnt_after, cnt_late;
        bus.in_valid = 1'b0;  bus.in_dataA = '0;  bus.in_dataB = '0;  bus.printtingScreen = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_dataA = '0; bus0.in_dataB = '0; bus0.printtingScreen = 1'b0;

        // Reset state
        do_reset();
        chk("rst_clk_en", 64'(bus.out_clk_en), 64'd0);
        chk("rst_dataA", 64'(bus.out_dataA), 64'd0);
        chk("rst_dataB", 64'(bus.out_dataB), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_issued", 64'(issued_count), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);

        // T1: single instruction latency and hold-off
        push(32'h0000_0001, 32'h0000_01FF, 1'b1);
        n = cyc;
        chk("t1_count_after_push", 64'(fifo_count), 64'd1);
        chk("t1_no_early_pulse", 64'(bus.out_clk_en), 64'd0);
        tick();
        chk("t1_pulse", 64'(bus.out_clk_en), 64'd1);
        chk("t1_dataA", 64'(bus.out_dataA), 64'h1);
        chk("t1_dataB", 64'(bus.out_dataB), 64'h1FF);
        chk("t1_busy_pulse", 64'(busy), 64'd1);
        tick();
        chk("t1_pulse_end", 64'(bus.out_clk_en), 64'd0);
        chk("t1_data_stable", 64'(bus.out_dataA), 64'h1);
        tick(GAP - 1);
        chk("t1_busy_hold", 64'(busy), 64'd1);
        tick();
        chk("t1_busy_idle", 64'(busy), 64'd0);
        chk("t1_npulse", 64'(pt.size()), 64'd1);
        if (pt.size() == 1) chk("t1_latency", 64'(pt[0] - n), 64'd1);

        // T2: three back-to-back pushes, pulses GAP+2 apart in order
        do_reset();
        push($urandom, $urandom, 1'b1);
        m = cyc;
        push($urandom, $urandom, 1'b1);
        push($urandom, $urandom, 1'b1);
        tick(20);
        chk("t2_npulse", 64'(pt.size()), 64'd3);
        if (pt.size() == 3) begin
            chk("t2_first", 64'(pt[0] - m), 64'd1);
            chk("t2_gap1", 64'(pt[1] - pt[0]), 64'(GAP + 2));
            chk("t2_gap2", 64'(pt[2] - pt[1]), 64'(GAP + 2));
        end
        chk("t2_drained", 64'(sb.size()), 64'd0);

        // T3: blocked while screen busy, fill, refuse ninth, release
        bus.printtingScreen = 1'b1;
        do_reset();
        tick(3);
        push($urandom, $urandom, 1'b1);
        p1 = cyc;
        for (int i = 1; i < DEPTH; i++) push($urandom, $urandom, 1'b1);
        chk("t3_count_full", 64'(fifo_count), 64'd8);
        chk("t3_ready_full", 64'(bus.in_ready), 64'd0);
        push(32'hDEAD_BEEF, 32'hBAD0_BAD0, 1'b0);
        chk("t3_count_after_refuse", 64'(fifo_count), 64'd8);
        tick(5);
        chk("t3_no_pulse", 64'(pt.size()), 64'd0);
        bus.printtingScreen = 1'b0;
        e = cyc;
        tick(3 + 7 * (GAP + 2) + 5);
        chk("t3_npulse", 64'(pt.size()), 64'd8);
        if (pt.size() == 8) begin
            chk("t3_release_lat", 64'(pt[0] - e), 64'd3);
            for (int i = 1; i < 8; i++) chk("t3_spacing", 64'(pt[i] - pt[i-1]), 64'(GAP + 2));
        end
        chk("t3_drained", 64'(sb.size()), 64'd0);
`ifdef ISSUER_STATS_EN
        chk("t3_issued", 64'(issued_count), 64'd8);
        chk("t3_stall", 64'(stall_count), 64'(e + 2 - p1));
`else
        chk("t3_issued_off", 64'(issued_count), 64'd0);
        chk("t3_stall_off", 64'(stall_count), 64'd0);
`endif

        // T4: push refused when full even with a same-cycle pop; pointer wrap
        bus.printtingScreen = 1'b1;
        do_reset();
        tick(3);
        for (int i = 0; i < DEPTH; i++) push($urandom, $urandom, 1'b1);
        bus.printtingScreen = 1'b0;
        tick(2);
        bus.in_valid = 1'b1;
        bus.in_dataA = 32'hFFFF_0000;
        bus.in_dataB = 32'h0000_FFFF;
        chk("t4_ready_full", 64'(bus.in_ready), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("t4_pop_edge", 64'(bus.out_clk_en), 64'd1);
        chk("t4_count_after", 64'(fifo_count), 64'd7);
        for (int i = 0; i < 20; i++) begin
            push($urandom, $urandom, 1'b1);
            tick(11);
        end
        tick(60);
        chk("t4_drained", 64'(sb.size()), 64'd0);
        chk("t4_count_end", 64'(fifo_count), 64'd0);
        chk("t4_npulse", 64'(pt.size()), 64'd28);

        // T5: reset during a pulse with five entries queued
        bus.printtingScreen = 1'b1;
        do_reset();
        tick(3);
        for (int i = 0; i < 6; i++) push($urandom, $urandom, 1'b1);
        bus.printtingScreen = 1'b0;
        tick(3);
        chk("t5_pulse", 64'(bus.out_clk_en), 64'd1);
        chk("t5_queued", 64'(fifo_count), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_clk_en_cut", 64'(bus.out_clk_en), 64'd0);
        chk("t5_count_flush", 64'(fifo_count), 64'd0);
        chk("t5_ready", 64'(bus.in_ready), 64'd1);
        tick();
        sb.delete();
        tick(20);
        chk("t5_no_more_pulses", 64'(pt.size()), 64'd1);
        chk("t5_count_end", 64'(fifo_count), 64'd0);

        // T6: GAP_CYCLES=0 instance, pulses every 2 cycles, then blocked mid-burst
        do_reset();
        push0($urandom, $urandom);
        m = cyc;
        for (int i = 1; i < 4; i++) push0($urandom, $urandom);
        tick(10);
        chk("t6_npulse", 64'(pt0.size()), 64'd4);
        if (pt0.size() == 4) begin
            chk("t6_first", 64'(pt0[0] - m), 64'd1);
            for (int i = 1; i < 4; i++) chk("t6_spacing", 64'(pt0[i] - pt0[i-1]), 64'd2);
        end
        do_reset();
        push0($urandom, $urandom);
        push0($urandom, $urandom);
        bus0.printtingScreen = 1'b1;
        r = cyc;
        for (int i = 2; i < 6; i++) push0($urandom, $urandom);
        tick(20);
        cnt_after = 0;
        cnt_late  = 0;
        foreach (pt0[i]) begin
            if (pt0[i] > r) cnt_after++;
            if (pt0[i] > r + 2) cnt_late++;
        end
        chk("t6_after_raise_le2", 64'(cnt_after <= 2), 64'd1);
        chk("t6_blocked", 64'(cnt_late), 64'd0);
        chk("t6_count_blocked", 64'(fifo_count0), 64'd4);
        bus0.printtingScreen = 1'b0;
        d = cyc;
        tick(15);
        chk("t6_npulse_total", 64'(pt0.size()), 64'd6);
        if (pt0.size() == 6) chk("t6_release_lat", 64'(pt0[2] - d), 64'd3);
        chk("t6_drained", 64'(sb0.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
